// File: rtl/video_pkg.sv
// Shared types and default PAL (720x576 @ 27 MHz) timing constants for the
// video timing generator.
package video_pkg;

    typedef enum logic [1:0] {
        DISP  = 2'd0,
        FRONT = 2'd1,
        SYNC  = 2'd2,
        BACK  = 2'd3
    } axis_state_t;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int PAL_HDISP = 720;
    localparam int PAL_HFP   = 12;
    localparam int PAL_HSYNC = 64;
    localparam int PAL_HBP   = 68;
    localparam int PAL_VDISP = 576;
    localparam int PAL_VFP   = 5;
    localparam int PAL_VSYNC = 5;
    localparam int PAL_VBP   = 39;

    function automatic axis_state_t next_state(input axis_state_t s);
        axis_state_t n;
        n = DISP;
        case (s)
            DISP:  n = FRONT;
            FRONT: n = SYNC;
            SYNC:  n = BACK;
            BACK:  n = DISP;
            default: n = DISP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One axis of the raster: DISP -> FRONT -> SYNC -> BACK, each phase a fixed
// number of enabled ticks, with the counter restarting at every phase entry.
module timing_axis
    import video_pkg::*;
#(
    parameter int DISP_LEN = PAL_HDISP,
    parameter int FP_LEN   = PAL_HFP,
    parameter int SYNC_LEN = PAL_HSYNC,
    parameter int BP_LEN   = PAL_HBP,
    parameter int CNT_W    = X_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    output axis_state_t      state,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] end_cnt;
    logic             at_end;

    always_comb begin
        end_cnt = CNT_W'(BP_LEN - 1);
        case (state)
            DISP:    end_cnt = CNT_W'(DISP_LEN - 1);
            FRONT:   end_cnt = CNT_W'(FP_LEN - 1);
            SYNC:    end_cnt = CNT_W'(SYNC_LEN - 1);
            BACK:    end_cnt = CNT_W'(BP_LEN - 1);
            default: end_cnt = CNT_W'(BP_LEN - 1);
        endcase
    end

    assign at_end = (count == end_cnt);
    // Final tick of the whole period, independent of enable so the parent can
    // AND axes together.
    assign last   = (state == BACK) && at_end;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= DISP;
            count <= '0;
        end else if (en) begin
            if (at_end) begin
                state <= next_state(state);
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: paces an upstream RGB pixel stream into the active
// area and emits registered syncs, blanking, coordinates and underflow count.
module video_timing
    import video_pkg::*;
#(
    parameter int HDISP = PAL_HDISP,
    parameter int HFP   = PAL_HFP,
    parameter int HSYNC = PAL_HSYNC,
    parameter int HBP   = PAL_HBP,
    parameter int VDISP = PAL_VDISP,
    parameter int VFP   = PAL_VFP,
    parameter int VSYNC = PAL_VSYNC,
    parameter int VBP   = PAL_VBP
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic [23:0]    pix_data,
    input  logic           pix_valid,
    output logic           pix_ready,
    output logic           hs,
    output logic           vs,
    output logic           blank,
    output logic [7:0]     r,
    output logic [7:0]     g,
    output logic [7:0]     b,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           frame_start,
    output logic [15:0]    uf_cnt
);

    axis_state_t    hstate, vstate;
    logic [X_W-1:0] hcount;
    logic [Y_W-1:0] vcount;
    logic           h_last, v_last;
    logic           frame_end;
    logic           active;
    logic           sof;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    timing_axis #(
        .DISP_LEN(HDISP), .FP_LEN(HFP), .SYNC_LEN(HSYNC), .BP_LEN(HBP), .CNT_W(X_W)
    ) u_h (
        .clk(clk), .nrst(nrst), .en(1'b1),
        .state(hstate), .count(hcount), .last(h_last)
    );

    timing_axis #(
        .DISP_LEN(VDISP), .FP_LEN(VFP), .SYNC_LEN(VSYNC), .BP_LEN(VBP), .CNT_W(Y_W)
    ) u_v (
        .clk(clk), .nrst(nrst), .en(h_last),
        .state(vstate), .count(vcount), .last(v_last)
    );

    assign frame_end = h_last && v_last;
    assign active    = (hstate == DISP) && (vstate == DISP);
    // Gated by reset so upstream never sees a request while the block is held.
    assign pix_ready = active && nrst;

    // Output stage: everything below is one clock behind the counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            uf_cnt      <= '0;
            sof         <= 1'b1;
        end else begin
            blank       <= !active;
            hs          <= (hstate != SYNC);
            vs          <= (vstate != SYNC);
            {r, g, b}   <= (active && pix_valid) ? pix_data : 24'd0;
            frame_start <= active && sof;
            // sof marks "next active pixel is (0,0)"; armed at frame end and reset.
            if (frame_end) begin
                sof <= 1'b1;
            end else if (active) begin
                sof <= 1'b0;
            end
            if (active) begin
                x <= hcount;
                y <= vcount;
            end
            if (active && !pix_valid) begin
                uf_cnt <= sat_inc(uf_cnt);
            end
        end
    end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameters HDISP 720, HFP 12, HSYNC 64, HBP 68: active pixels, front porch, sync and back porch per line, in clocks.
REQ-002 SHALL have parameters VDISP 576, VFP 5, VSYNC 5, VBP 39: active lines, front porch, sync and back porch per frame, in lines.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  pixel clock (27 MHz), rising edge only; nrst  in  1  asynchronous active-low reset, driven from the synchronised reset of the clk domain.
REQ-004 SHALL have ports pix_data in 24 (RGB 8:8:8, R in MSBs), pix_valid in 1, pix_ready out 1: upstream pixel stream.
REQ-005 SHALL have ports hs out 1 and vs out 1 (syncs, active low), and blank out 1 (high outside the active area).
REQ-006 SHALL have ports r, g, b out 8 each; x out X_W and y out Y_W (coordinate of the pixel currently on r/g/b).
REQ-007 SHALL have ports frame_start out 1 and uf_cnt out 16 (underflow count).

Function
REQ-008 Horizontal axis SHALL cycle DISP -> FRONT -> SYNC -> BACK -> DISP, spending HDISP, HFP, HSYNC and HBP clocks respectively; its counter restarts at 0 on each state entry.
REQ-009 Line end SHALL be the last BACK clock; the vertical axis SHALL cycle DISP -> FRONT -> SYNC -> BACK over VDISP, VFP, VSYNC and VBP lines, advancing only on line end.
REQ-010 active SHALL be (hstate==DISP && vstate==DISP); pix_ready SHALL equal active combinationally, with no dependency on pix_valid.
REQ-011 A pixel SHALL be consumed on a clock where pix_valid && pix_ready; upstream SHALL hold pix_data stable while pix_valid && !pix_ready.
REQ-012 All outputs except pix_ready SHALL be registered with 1 clock latency from the counter state: blank <= !active; hs <= !(hstate==SYNC); vs <= !(vstate==SYNC).
REQ-013 When active && pix_valid, {r,g,b} SHALL register pix_data; otherwise {r,g,b} SHALL register 0.
REQ-014 When active && !pix_valid (underflow), the block SHALL output black, SHALL NOT stall the timing, and SHALL increment uf_cnt, saturating at 16'hFFFF.
REQ-015 x and y SHALL register the DISP-state counters when active and hold their last value when blank=1.
REQ-016 frame_start SHALL pulse high for exactly one clock, coincident with the output of pixel (0,0) on r/g/b.
REQ-017 Line period SHALL be HDISP+HFP+HSYNC+HBP clocks (864 by default); frame period SHALL be line period x (VDISP+VFP+VSYNC+VBP) (625 lines by default).
REQ-018 Wrap-around from the last BACK line/clock SHALL go to DISP/0 on both axes in the same cycle, with no idle clock.
REQ-019 Every parameter SHALL be >=1; X_W and Y_W SHALL hold HDISP-1 and VDISP-1.

Reset
REQ-020 With nrst low, the block SHALL asynchronously set hstate=vstate=DISP and both counters to 0; hs=vs=1, blank=1, r=g=b=0, x=y=0, frame_start=0, uf_cnt=0.
REQ-021 pix_ready SHALL be 0 while nrst is low.
REQ-022 On the first clock after nrst releases, pix_ready SHALL be 1 (pixel (0,0) requested), and frame_start SHALL be 1 on the following clock.
REQ-023 Reset asserted mid-line or mid-frame SHALL abort the frame with no partial recovery; the timing restarts at (0,0).

Structure
REQ-024 Package video_pkg SHALL hold the axis state enum (DISP, FRONT, SYNC, BACK), X_W=11, Y_W=10 and the default PAL timing constants.
REQ-025 One sub-module, timing_axis, SHALL implement the 4-state counter with an enable input, a last-of-period output and the state/count outputs; it is instantiated for H (enable=1) and for V (enable=line end).

Verification (bench parameters HDISP=4 HFP=1 HSYNC=2 HBP=1, VDISP=3 VFP=1 VSYNC=1 VBP=1: line 8 clocks, frame 48 clocks)
REQ-026 Release reset with pix_valid=1 held -> frame_start pulses every 48 clocks; blank low for 4 of every 8 clocks on 3 lines per frame; hs low for 2 clocks per line; vs low for 8 consecutive clocks per frame.
REQ-027 Incrementing pix_data 0,1,2,... sent with valid -> r/g/b carry 0..11 in order, x=0..3 and y=0..2, each 1 clock after acceptance.
REQ-028 pix_valid=0 for 3 active clocks -> r=g=b=0 on those pixels, uf_cnt=3, frame period unchanged.
REQ-029 Force uf_cnt to 16'hFFFE, then cause 3 underflows -> uf_cnt stays at 16'hFFFF.
REQ-030 Assert nrst mid-line 2 -> all outputs take their reset values immediately (asynchronously, not on a clock edge); after release, frame_start occurs 2 clocks later with x=0, y=0.
